id_ex_skid: RTL and testbench

- Decode-to-execute pipeline boundary placed directly upstream of the execute stage.
- Registers decoded operands, instruction, PC, rd address and write enable, and presents them to execute.
- Honours the hold (stall) and jump (flush) requests from ctrl.
- A one-entry skid buffer lets decode use a registered valid/ready handshake without a combinational path from hold_flag to decode.

---
 rtl/id_ex_skid_pkg.sv | 23 ++
 rtl/id_ex_skid_entry_reg.sv | 35 +++
 rtl/id_ex_skid.sv | 112 +++++++++++
 tb/tb_id_ex_skid.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_skid_pkg.sv
// Shared types and constants for the decode-to-execute boundary:
// the entry bundle carried by the main and skid registers.
package id_ex_skid_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;
  localparam int RD_W   = 5;

  localparam logic [INST_W-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic              reg_wen;
    logic [RD_W-1:0]   rd;
  } entry_t;

  localparam entry_t ENTRY_ZERO = '{inst: '0, addr: '0, op1: '0, op2: '0,
                                    reg_wen: 1'b0, rd: '0};

endpackage

// File: rtl/id_ex_skid_entry_reg.sv
// Enable-loaded register holding one pipeline entry bundle; keeps its
// contents until the next load so a stalled entry stays stable.
module pipe_entry_reg
  import id_ex_skid_pkg::*;
#(
  parameter entry_t RST_VAL = ENTRY_ZERO
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load_i,
  input  entry_t d_i,
  output entry_t q_o
);

  entry_t entry_q;
  entry_t entry_d;

  always_comb begin
    entry_d = entry_q;
    if (load_i) begin
      entry_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= RST_VAL;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign q_o = entry_q;

endmodule

// File: rtl/id_ex_skid.sv
// ID/EX pipeline register with a one-entry skid buffer so decode sees a
// registered ready that does not depend combinationally on hold_flag_i.
module id_ex_skid
  import id_ex_skid_pkg::*;
#(
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INST_W-1:0] inst_i,
  input  logic [XLEN-1:0]   inst_addr_i,
  input  logic [XLEN-1:0]   op1_i,
  input  logic [XLEN-1:0]   op2_i,
  input  logic              reg_wen_i,
  input  logic [RD_W-1:0]   rd_addr_i,
  input  logic              id_valid_i,
  output logic              id_ready_o,
  input  logic              hold_flag_i,
  input  logic              jump_en_i,
  output logic [INST_W-1:0] inst_o,
  output logic [XLEN-1:0]   inst_addr_o,
  output logic [XLEN-1:0]   op1_o,
  output logic [XLEN-1:0]   op2_o,
  output logic              reg_wen_o,
  output logic [RD_W-1:0]   rd_addr_o,
  output logic              ex_valid_o
);

  localparam entry_t MAIN_RST = '{inst: NOP_INST, addr: '0, op1: '0, op2: '0,
                                  reg_wen: 1'b0, rd: '0};

  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   main_load, skid_load, main_from_skid;
  logic   accept;
  entry_t in_entry, main_entry, skid_entry, main_in;

  assign in_entry = '{inst: inst_i, addr: inst_addr_i, op1: op1_i, op2: op2_i,
                      reg_wen: reg_wen_i, rd: rd_addr_i};

  assign id_ready_o = !skid_valid_q;
  assign accept     = id_valid_i & id_ready_o;

  always_comb begin
    main_valid_d   = main_valid_q;
    skid_valid_d   = skid_valid_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (jump_en_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!hold_flag_i) begin
      if (skid_valid_q) begin
        // Skid drains first; ready is low so nothing new can arrive now.
        main_load      = 1'b1;
        main_from_skid = 1'b1;
        main_valid_d   = 1'b1;
        skid_valid_d   = 1'b0;
      end else begin
        main_load    = accept;
        main_valid_d = accept;
      end
    end else if (accept) begin
      if (!main_valid_q) begin
        main_load    = 1'b1;
        main_valid_d = 1'b1;
      end else begin
        skid_load    = 1'b1;
        skid_valid_d = 1'b1;
      end
    end
  end

  assign main_in = main_from_skid ? skid_entry : in_entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  pipe_entry_reg #(.RST_VAL(MAIN_RST)) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (main_load),
    .d_i    (main_in),
    .q_o    (main_entry)
  );

  pipe_entry_reg #(.RST_VAL(ENTRY_ZERO)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (skid_load),
    .d_i    (in_entry),
    .q_o    (skid_entry)
  );

  // Stale main data is masked by the registered valid, never by any input.
  assign ex_valid_o  = main_valid_q;
  assign inst_o      = main_valid_q ? main_entry.inst    : NOP_INST;
  assign inst_addr_o = main_valid_q ? main_entry.addr    : '0;
  assign op1_o       = main_valid_q ? main_entry.op1     : '0;
  assign op2_o       = main_valid_q ? main_entry.op2     : '0;
  assign reg_wen_o   = main_valid_q ? main_entry.reg_wen : 1'b0;
  assign rd_addr_o   = main_valid_q ? main_entry.rd      : '0;

endmodule

// File: tb/tb_id_ex_skid.sv
// Directed bench for id_ex_skid: streaming, stall with skid capture,
// flush, flush+hold, hold into empty main and asynchronous reset.
module tb_id_ex_skid;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_i, inst_addr_i, op1_i, op2_i;
  logic        reg_wen_i;
  logic [4:0]  rd_addr_i;
  logic        id_valid_i, id_ready_o, hold_flag_i, jump_en_i;
  logic [31:0] inst_o, inst_addr_o, op1_o, op2_o;
  logic        reg_wen_o;
  logic [4:0]  rd_addr_o;
  logic        ex_valid_o;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  id_ex_skid dut (
    .clk(clk), .rst_n(rst_n), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .op1_i(op1_i), .op2_i(op2_i), .reg_wen_i(reg_wen_i), .rd_addr_i(rd_addr_i),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .hold_flag_i(hold_flag_i),
    .jump_en_i(jump_en_i), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .op1_o(op1_o), .op2_o(op2_o), .reg_wen_o(reg_wen_o), .rd_addr_o(rd_addr_o),
    .ex_valid_o(ex_valid_o)
  );

  always #5 clk = ~clk;

  // Beat contents are derived from the PC so every beat is distinguishable.
  function automatic logic [31:0] beat_inst(input logic [31:0] a);
    return 32'h0000_0093 | ({27'd0, a[6:2] + 5'd1} << 7) | (a << 20);
  endfunction
  function automatic logic [31:0] beat_op1(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  task automatic offer(input logic v, input logic [31:0] a);
    id_valid_i  = v;
    inst_addr_i = a;
    inst_i      = beat_inst(a);
    op1_i       = beat_op1(a);
    op2_i       = ~a;
    reg_wen_i   = 1'b1;
    rd_addr_i   = a[6:2] + 5'd1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (ex_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ex_valid_o); end
    checks++;
    if (inst_o !== NOP) begin errors++; $display("FAIL reset_inst: got %h want %h", inst_o, NOP); end
    checks++;
    if (id_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", id_ready_o); end
    checks++;
    if ({inst_addr_o, op1_o, op2_o, reg_wen_o, rd_addr_o} !== '0) begin
      errors++; $display("FAIL reset_data: addr %h op1 %h op2 %h wen %b rd %0d want all 0",
                         inst_addr_o, op1_o, op2_o, reg_wen_o, rd_addr_o);
    end
    $display("reset: valid=%b inst=%h ready=%b", ex_valid_o, inst_o, id_ready_o);
  endtask

  task automatic test_stream();
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 32'(4 * i);
      offer(1'b1, a);
      checks++;
      if (id_ready_o !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b want 1", i, id_ready_o); end
      step();
      checks++;
      if (ex_valid_o !== 1'b1 || inst_addr_o !== a || inst_o !== beat_inst(a) ||
          op1_o !== beat_op1(a) || op2_o !== ~a || rd_addr_o !== a[6:2] + 5'd1 || reg_wen_o !== 1'b1) begin
        errors++; $display("FAIL stream_out[%0d]: valid %b addr %h inst %h want valid 1 addr %h inst %h",
                           i, ex_valid_o, inst_addr_o, inst_o, a, beat_inst(a));
      end
      $display("stream: beat %0d addr=%h inst=%h", i, inst_addr_o, inst_o);
    end
    offer(1'b0, 32'h0);
    step();
    checks++;
    if (ex_valid_o !== 1'b0 || inst_o !== NOP) begin
      errors++; $display("FAIL stream_drain: valid %b inst %h want 0 %h", ex_valid_o, inst_o, NOP);
    end
  endtask

  task automatic test_hold();
    offer(1'b1, 32'h0); step();
    offer(1'b1, 32'h4); step();
    hold_flag_i = 1'b1;
    offer(1'b1, 32'h8); step();
    offer(1'b1, 32'hC);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (inst_addr_o !== 32'h4 || ex_valid_o !== 1'b1 || id_ready_o !== 1'b0) begin
        errors++; $display("FAIL hold_frozen[%0d]: addr %h valid %b ready %b want 4 1 0",
                           i, inst_addr_o, ex_valid_o, id_ready_o);
      end
      $display("hold: cycle %0d addr=%h ready=%b", i, inst_addr_o, id_ready_o);
      if (i < 2) step();
    end
    hold_flag_i = 1'b0;
    step();
    checks++;
    if (inst_addr_o !== 32'h8 || inst_o !== beat_inst(32'h8) || ex_valid_o !== 1'b1 || id_ready_o !== 1'b1) begin
      errors++; $display("FAIL hold_release_skid: addr %h valid %b ready %b want 8 1 1",
                         inst_addr_o, ex_valid_o, id_ready_o);
    end
    step();
    checks++;
    if (inst_addr_o !== 32'hC || ex_valid_o !== 1'b1) begin
      errors++; $display("FAIL hold_release_next: addr %h valid %b want c 1", inst_addr_o, ex_valid_o);
    end
    $display("hold: release addr=%h", inst_addr_o);
    offer(1'b0, 32'h0); step();
  endtask

  task automatic test_flush();
    offer(1'b1, 32'h10); step();
    hold_flag_i = 1'b1;
    offer(1'b1, 32'h14); step();
    checks++;
    if (id_ready_o !== 1'b0 || inst_addr_o !== 32'h10) begin
      errors++; $display("FAIL flush_setup: ready %b addr %h want 0 10", id_ready_o, inst_addr_o);
    end
    hold_flag_i = 1'b0;
    jump_en_i   = 1'b1;
    offer(1'b1, 32'h18); step();
    checks++;
    if (ex_valid_o !== 1'b0 || inst_o !== NOP || reg_wen_o !== 1'b0 || id_ready_o !== 1'b1) begin
      errors++; $display("FAIL flush_clear: valid %b inst %h wen %b ready %b want 0 %h 0 1",
                         ex_valid_o, inst_o, reg_wen_o, id_ready_o, NOP);
    end
    // Ready is high now, so 0x18 is accepted during the flush and must vanish.
    step();
    jump_en_i = 1'b0;
    offer(1'b0, 32'h0); step();
    checks++;
    if (ex_valid_o !== 1'b0 || inst_addr_o !== 32'h0) begin
      errors++; $display("FAIL flush_discard: valid %b addr %h want 0 0", ex_valid_o, inst_addr_o);
    end
    $display("flush: valid=%b inst=%h ready=%b", ex_valid_o, inst_o, id_ready_o);
  endtask

  task automatic test_flush_hold();
    offer(1'b1, 32'h50); step();
    hold_flag_i = 1'b1;
    offer(1'b1, 32'h54); step();
    offer(1'b1, 32'h58);
    jump_en_i = 1'b1;
    step();
    checks++;
    if (ex_valid_o !== 1'b0 || inst_o !== NOP || id_ready_o !== 1'b1) begin
      errors++; $display("FAIL flush_hold: valid %b inst %h ready %b want 0 %h 1",
                         ex_valid_o, inst_o, id_ready_o, NOP);
    end
    $display("flush_hold: valid=%b ready=%b", ex_valid_o, id_ready_o);
    jump_en_i = 1'b0;
    offer(1'b0, 32'h0);
    hold_flag_i = 1'b0;
    step();
  endtask

  task automatic test_hold_empty();
    hold_flag_i = 1'b1;
    offer(1'b1, 32'h20); step();
    checks++;
    if (ex_valid_o !== 1'b1 || inst_addr_o !== 32'h20 || id_ready_o !== 1'b1) begin
      errors++; $display("FAIL hold_empty_load: valid %b addr %h ready %b want 1 20 1",
                         ex_valid_o, inst_addr_o, id_ready_o);
    end
    offer(1'b0, 32'h0);
    step(); step();
    checks++;
    if (ex_valid_o !== 1'b1 || inst_addr_o !== 32'h20 || op1_o !== beat_op1(32'h20)) begin
      errors++; $display("FAIL hold_empty_stable: valid %b addr %h op1 %h want 1 20 %h",
                         ex_valid_o, inst_addr_o, op1_o, beat_op1(32'h20));
    end
    $display("hold_empty: addr=%h valid=%b", inst_addr_o, ex_valid_o);
    hold_flag_i = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    offer(1'b1, 32'h30); step();
    hold_flag_i = 1'b1;
    offer(1'b1, 32'h34); step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ex_valid_o !== 1'b0 || inst_o !== NOP || id_ready_o !== 1'b1 || inst_addr_o !== 32'h0) begin
      errors++; $display("FAIL async_reset: valid %b inst %h ready %b addr %h want 0 %h 1 0",
                         ex_valid_o, inst_o, id_ready_o, inst_addr_o, NOP);
    end
    hold_flag_i = 1'b0;
    offer(1'b1, 32'h40);
    #2 rst_n = 1'b1;
    step();
    checks++;
    if (ex_valid_o !== 1'b1 || inst_addr_o !== 32'h40 || inst_o !== beat_inst(32'h40)) begin
      errors++; $display("FAIL async_reset_resume: valid %b addr %h want 1 40", ex_valid_o, inst_addr_o);
    end
    $display("async_reset: resumed addr=%h", inst_addr_o);
    offer(1'b0, 32'h0); step();
  endtask

  initial begin
    rst_n       = 1'b0;
    hold_flag_i = 1'b0;
    jump_en_i   = 1'b0;
    offer(1'b0, 32'h0);
    #1;
    test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    test_stream();
    test_hold();
    test_flush();
    test_flush_hold();
    test_hold_empty();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
